// File: rtl/riscv_types.sv
// Shared FPU/EXE types; wb_entry_t carries one queued writeback.
// FPU_WB_FFLAGS_EN adds the exception-flag field to wb_entry_t.
package riscv_types;

  typedef struct packed {
    logic [4:0] rd_addr;
    logic       rd_wr;
    logic       is_float;
    logic [2:0] rm;
  } exe_p_mux_bus_type;

  // fflags bit positions (NV,DZ,OF,UF,NX)
  localparam int unsigned FFLAG_NV = 4;
  localparam int unsigned FFLAG_DZ = 3;
  localparam int unsigned FFLAG_OF = 2;
  localparam int unsigned FFLAG_UF = 1;
  localparam int unsigned FFLAG_NX = 0;
  localparam int unsigned FFLAG_W  = 5;

  typedef struct packed {
    logic [31:0]       result;
    exe_p_mux_bus_type pipelined;
`ifdef FPU_WB_FFLAGS_EN
    logic [FFLAG_W-1:0] fflags;
`endif
  } wb_entry_t;

endpackage

// File: rtl/fpu_wb_collector_fifo.sv
// Dual-push single-pop result queue; slot 0 is written ahead of slot 1.
// Caller compacts pushes so push1_s implies push0_s.
module fpu_wb_fifo
  import riscv_types::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push0_s,
  input  wb_entry_t     push0_data_s,
  input  logic          push1_s,
  input  wb_entry_t     push1_data_s,
  input  logic          pop_s,
  output logic          head_valid,
  output wb_entry_t     head_data,
  output logic [CW-1:0] count
);

  wb_entry_t     mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] push_cnt_s;
  logic [PW-1:0] wr1_ptr_s;

  // Push count and second write slot
  always_comb begin
    push_cnt_s = CW'(push0_s) + CW'(push1_s);
    wr1_ptr_s  = wr_ptr_r + PW'(push0_s);
  end

  // Queue storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {$bits(wb_entry_t){1'b0}};
      end
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push0_s) mem_r[wr_ptr_r] <= push0_data_s;
      if (push1_s) mem_r[wr1_ptr_s] <= push1_data_s;
      wr_ptr_r <= wr_ptr_r + push_cnt_s[PW-1:0];
      rd_ptr_r <= rd_ptr_r + PW'(pop_s);
      count_r  <= count_r + push_cnt_s - CW'(pop_s);
    end
  end

  // Head view is zero when empty
  always_comb begin
    head_valid = (count_r != {CW{1'b0}});
    count      = count_r;
    if (head_valid) begin
      head_data = mem_r[rd_ptr_r];
    end else begin
      head_data = {$bits(wb_entry_t){1'b0}};
    end
  end

endmodule

// File: rtl/fpu_wb_collector.sv
// Collects FPU misc-unit (A) and fdiv/fsqrt (B) completions into an ordered writeback queue.
// Define FPU_WB_FFLAGS_EN to carry exception flags through the queue.
module fpu_wb_collector
  import riscv_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_last,
  input  logic [31:0]       a_result,
  input  exe_p_mux_bus_type a_pipelined_signals,
  input  logic              b_last,
  input  logic [31:0]       b_result,
  input  exe_p_mux_bus_type b_pipelined_signals,
`ifdef FPU_WB_FFLAGS_EN
  input  logic [4:0]        a_fflags,
  input  logic [4:0]        b_fflags,
  output logic [4:0]        wb_fflags,
`endif
  input  logic              wb_ready,
  output logic              wb_valid,
  output logic [31:0]       wb_result,
  output exe_p_mux_bus_type wb_pipelined_signals,
  output logic              o_stall,
  output logic              o_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t     a_entry_s, b_entry_s, push0_data_s, push1_data_s, head_s;
  logic          head_valid_s, pop_s, a_acc_s, b_acc_s, drop_s;
  logic          push0_s, push1_s;
  logic [CW-1:0] count_s, free_s, free_ap_s;
  logic          overflow_r;

  // Pack incoming completions
  always_comb begin
    a_entry_s.result    = a_result;
    a_entry_s.pipelined = a_pipelined_signals;
    b_entry_s.result    = b_result;
    b_entry_s.pipelined = b_pipelined_signals;
`ifdef FPU_WB_FFLAGS_EN
    a_entry_s.fflags    = a_fflags;
    b_entry_s.fflags    = b_fflags;
`endif
  end

  // Space check after same-cycle pop; B has priority over A for the last slot
  always_comb begin
    pop_s     = head_valid_s && wb_ready;
    free_s    = CW'(DEPTH) - count_s;
    free_ap_s = free_s + CW'(pop_s);
    if (b_last) begin
      b_acc_s = (free_ap_s != {CW{1'b0}});
      a_acc_s = a_last && (free_ap_s >= CW'(2));
    end else begin
      b_acc_s = 1'b0;
      a_acc_s = a_last && (free_ap_s != {CW{1'b0}});
    end
    drop_s  = (a_last && !a_acc_s) || (b_last && !b_acc_s);
    push0_s = b_acc_s || a_acc_s;
    push1_s = b_acc_s && a_acc_s;
    if (b_acc_s) begin
      push0_data_s = b_entry_s;
    end else begin
      push0_data_s = a_entry_s;
    end
    push1_data_s = a_entry_s;
  end

  fpu_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .push0_s      (push0_s),
    .push0_data_s (push0_data_s),
    .push1_s      (push1_s),
    .push1_data_s (push1_data_s),
    .pop_s        (pop_s),
    .head_valid   (head_valid_s),
    .head_data    (head_s),
    .count        (count_s)
  );

  // Sticky overflow flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end
  end

  // Outputs come only from registered queue state
  always_comb begin
    wb_valid             = head_valid_s;
    wb_result            = head_s.result;
    wb_pipelined_signals = head_s.pipelined;
`ifdef FPU_WB_FFLAGS_EN
    wb_fflags            = head_s.fflags;
`endif
    o_stall              = (free_s < CW'(2));
    o_overflow           = overflow_r;
  end

endmodule
